// File: rtl/fifo_rr_read_arbiter_if.sv
// Bundle of the per-FIFO read-side signals and the merged downstream stream.
// The arbiter connects through the master modport; the FIFOs and the consumer
// connect through the slave modport.
interface fifo_rr_read_arbiter_if #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int SRC_ID_WIDTH = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]      i_fifo_empty;
  logic [NUM_SRC-1:0]      i_fifo_valid;
  logic [DATA_WIDTH-1:0]   i_fifo_data [NUM_SRC];
  logic [NUM_SRC-1:0]      o_fifo_rd_req;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [SRC_ID_WIDTH-1:0] o_src_id;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_busy;

  modport master (
    input  i_fifo_empty, i_fifo_valid, i_fifo_data, i_ready,
    output o_fifo_rd_req, o_data, o_src_id, o_valid, o_busy
  );

  modport slave (
    output i_fifo_empty, i_fifo_valid, i_fifo_data, i_ready,
    input  o_fifo_rd_req, o_data, o_src_id, o_valid, o_busy
  );
endinterface

// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin read scheduler: grants one FIFO at a time for bursts of up to
// BURST_LEN reads, captures the 1-cycle-latency read data into a 2-entry
// output buffer and tags each word with the index of the FIFO it came from.
module fifo_rr_read_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LEN    = 4,
  parameter int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ena,
  fifo_rr_read_arbiter_if.master bus
);

  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);
  localparam logic [CNT_WIDTH-1:0]    BURST_LAST = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [SRC_ID_WIDTH-1:0] LAST_SRC   = SRC_ID_WIDTH'(NUM_SRC - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_reg, state_next;
  logic [SRC_ID_WIDTH-1:0] owner_reg, owner_next;
  logic [SRC_ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_WIDTH-1:0]    burst_cnt_reg, burst_cnt_next;
  logic                    inflight_reg, inflight_next;
  logic [SRC_ID_WIDTH-1:0] inflight_id_reg, inflight_id_next;

  // Output buffer: two entries, written in capture order.
  logic [DATA_WIDTH-1:0]   buf_data_reg [2];
  logic [SRC_ID_WIDTH-1:0] buf_id_reg   [2];
  logic                    wr_ptr_reg;
  logic                    rd_ptr_reg;
  logic [1:0]              occ_reg, occ_next;

  logic       valid;
  logic       pop;
  logic       capture;
  logic       issue;
  logic       owner_empty;
  logic       credit_ok;
  logic [2:0] demand;

  // First non-empty index strictly after ptr, wrapping modulo NUM_SRC.
  function automatic logic [SRC_ID_WIDTH-1:0] pick_next(
    input logic [SRC_ID_WIDTH-1:0] ptr,
    input logic [NUM_SRC-1:0]      empty
  );
    logic [SRC_ID_WIDTH-1:0] sel;
    logic [SRC_ID_WIDTH-1:0] idx_w;
    logic                    found;
    int                      idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = SRC_ID_WIDTH'(idx);
      if (!found && !empty[idx_w]) begin
        sel   = idx_w;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign valid       = (occ_reg != 2'd0);
  assign pop         = valid && bus.i_ready;
  assign owner_empty = bus.i_fifo_empty[owner_reg];
  // Words already held or on their way must leave room for one more; a pop
  // this cycle frees a slot immediately.
  assign demand      = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign credit_ok   = demand < (3'd2 + {2'b00, pop});
  assign issue       = (state_reg == GRANT) && i_ena && !owner_empty && credit_ok;
  // Only the FIFO we actually read from, and only while that read is pending.
  assign capture     = inflight_reg && bus.i_fifo_valid[inflight_id_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_rd_req
      assign bus.o_fifo_rd_req[gi] = issue && (owner_reg == SRC_ID_WIDTH'(gi));
    end
  endgenerate

  // Grant FSM: pick the next owner in IDLE, run the burst in GRANT.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_ena && !(&bus.i_fifo_empty)) begin
          owner_next     = pick_next(rr_ptr_reg, bus.i_fifo_empty);
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (i_ena) begin
          if (owner_empty) begin
            state_next  = IDLE;
            rr_ptr_next = owner_reg;
          end else if (issue) begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
            if (burst_cnt_reg == BURST_LAST) begin
              state_next  = IDLE;
              rr_ptr_next = owner_reg;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending-read tracking and buffer occupancy bookkeeping.
  always_comb begin
    inflight_next    = inflight_reg;
    inflight_id_next = inflight_id_reg;
    occ_next         = occ_reg;
    if (issue) begin
      inflight_next    = 1'b1;
      inflight_id_next = owner_reg;
    end else if (capture) begin
      inflight_next = 1'b0;
    end
    case ({capture, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      rr_ptr_reg      <= LAST_SRC;
      burst_cnt_reg   <= '0;
      inflight_reg    <= 1'b0;
      inflight_id_reg <= '0;
      occ_reg         <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      rr_ptr_reg      <= rr_ptr_next;
      burst_cnt_reg   <= burst_cnt_next;
      inflight_reg    <= inflight_next;
      inflight_id_reg <= inflight_id_next;
      occ_reg         <= occ_next;
      if (capture) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      // Buffer entry: written when a capture targets this slot.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          buf_data_reg[gi] <= '0;
          buf_id_reg[gi]   <= '0;
        end else if (capture && (wr_ptr_reg == 1'(gi))) begin
          buf_data_reg[gi] <= bus.i_fifo_data[inflight_id_reg];
          buf_id_reg[gi]   <= inflight_id_reg;
        end
      end
    end
  endgenerate

  assign bus.o_valid  = valid;
  assign bus.o_data   = buf_data_reg[rd_ptr_reg];
  assign bus.o_src_id = buf_id_reg[rd_ptr_reg];
  assign bus.o_busy   = (state_reg == GRANT) || inflight_reg || valid;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Directed bench for fifo_rr_read_arbiter with four behavioural FIFOs of
// 1-cycle read latency; expected values are hand-derived per scenario.
module tb_fifo_rr_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic [3:0] stray;

  always #5 clk = ~clk;

  fifo_rr_read_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(16)) bus ();

  fifo_rr_read_arbiter #(
    .NUM_SRC(4), .DATA_WIDTH(16), .BURST_LEN(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_ena  (ena),
    .bus    (bus)
  );

  // FIFO contents (written by the stimulus) and write pointers.
  logic [15:0] fdata [4][64];
  bit   [5:0]  fwr   [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_model
      bit   [5:0]  rd_ptr;
      logic        mvalid = 1'b0;
      logic [15:0] mdata  = 16'h0;
      // Simple FIFO read port: data and valid one cycle after a read request.
      always @(posedge clk) begin
        if (bus.o_fifo_rd_req[gi] && (rd_ptr != fwr[gi])) begin
          mvalid <= 1'b1;
          mdata  <= fdata[gi][rd_ptr];
          rd_ptr <= rd_ptr + 6'd1;
        end else begin
          mvalid <= 1'b0;
        end
      end
      assign bus.i_fifo_empty[gi] = (rd_ptr == fwr[gi]);
      assign bus.i_fifo_valid[gi] = mvalid | stray[gi];
      assign bus.i_fifo_data[gi]  = mdata;
    end
  endgenerate

  // Received-word log.
  logic [15:0] rx_data [128];
  logic [1:0]  rx_id   [128];
  int          rx_cnt = 0;

  // Record every accepted output word.
  always @(posedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      rx_data[rx_cnt] <= bus.o_data;
      rx_id[rx_cnt]   <= bus.o_src_id;
      rx_cnt          <= rx_cnt + 1;
      $display("xfer #%0d src=%0d data=%h", rx_cnt, bus.o_src_id, bus.o_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [15:0] d);
    fdata[s][fwr[s]] = d;
    fwr[s] = fwr[s] + 6'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (rx_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(rx_cnt), 32'(target));
  endtask

  task automatic check_rx(input string tag, input int idx, input logic [1:0] id, input logic [15:0] d);
    check({tag, "_id"},   32'(rx_id[idx]),   32'(id));
    check({tag, "_data"}, 32'(rx_data[idx]), 32'(d));
  endtask

  logic [3:0]  t1_req   [6];
  logic        t1_valid [6];
  logic [15:0] t1_data  [6];
  logic        t1_busy  [6];

  initial begin
    int base;
    int k;
    logic [1:0] src;
    int len;
    int first;

    rst_n = 1'b0;
    ena   = 1'b0;
    stray = 4'b0000;
    bus.i_ready = 1'b0;

    // Reset state.
    step(2);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_data",  32'(bus.o_data), 32'd0);
    check("rst_src",   32'(bus.o_src_id), 32'd0);
    check("rst_req",   32'(bus.o_fifo_rd_req), 32'd0);
    check("rst_busy",  32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single source, three words, ready held high.
    t1_req   = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    t1_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1_data  = '{16'h0, 16'h0, 16'hA00A, 16'hB00B, 16'hC00C, 16'h0};
    t1_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.i_ready = 1'b1;
    load(2'd1, 16'hA00A);
    load(2'd1, 16'hB00B);
    load(2'd1, 16'hC00C);
    ena = 1'b1;
    #1;
    check("t1_idle_req", 32'(bus.o_fifo_rd_req), 32'd0);
    step(1);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("t1_req_c%0d", c),   32'(bus.o_fifo_rd_req), 32'(t1_req[c]));
      check($sformatf("t1_valid_c%0d", c), 32'(bus.o_valid), 32'(t1_valid[c]));
      check($sformatf("t1_busy_c%0d", c),  32'(bus.o_busy), 32'(t1_busy[c]));
      if (t1_valid[c]) begin
        check($sformatf("t1_data_c%0d", c), 32'(bus.o_data), 32'(t1_data[c]));
        check($sformatf("t1_src_c%0d", c),  32'(bus.o_src_id), 32'd1);
      end
      step(1);
    end

    // Round robin: four FIFOs, six words each.
    do_reset();
    ena = 1'b0;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 6; i++)
        load(2'(s), 16'(s * 256 + i));
    base = rx_cnt;
    ena = 1'b1;
    wait_rx("t2_count", base + 24, 300);
    k = base;
    for (int g = 0; g < 8; g++) begin
      src   = 2'(g % 4);
      len   = (g < 4) ? 4 : 2;
      first = (g < 4) ? 0 : 4;
      for (int w = 0; w < len; w++) begin
        check_rx($sformatf("t2_g%0d_w%0d", g, w), k, src, 16'(int'(src) * 256 + first + w));
        k++;
      end
    end
    step(3);
    check("t2_idle_busy", 32'(bus.o_busy), 32'd0);

    // Backpressure: two words buffered, then resume on the first pop.
    do_reset();
    ena = 1'b0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(2'd0, 16'(16'h3000 + i));
    base = rx_cnt;
    ena = 1'b1;
    step(1);
    check("t3_req_c1", 32'(bus.o_fifo_rd_req), 32'b0001);
    step(1);
    check("t3_req_c2", 32'(bus.o_fifo_rd_req), 32'b0001);
    step(1);
    check("t3_req_c3", 32'(bus.o_fifo_rd_req), 32'd0);
    check("t3_valid_c3", 32'(bus.o_valid), 32'd1);
    check("t3_data_c3", 32'(bus.o_data), 32'h3000);
    step(1);
    check("t3_req_c4", 32'(bus.o_fifo_rd_req), 32'd0);
    check("t3_data_c4", 32'(bus.o_data), 32'h3000);
    step(1);
    check("t3_req_c5", 32'(bus.o_fifo_rd_req), 32'd0);
    check("t3_data_c5", 32'(bus.o_data), 32'h3000);
    check("t3_no_xfer", 32'(rx_cnt), 32'(base));
    bus.i_ready = 1'b1;
    #1;
    check("t3_resume", 32'(bus.o_fifo_rd_req), 32'b0001);
    wait_rx("t3_count", base + 4, 50);
    for (int i = 0; i < 4; i++)
      check_rx($sformatf("t3_w%0d", i), base + i, 2'd0, 16'(16'h3000 + i));

    // Stray valids must be ignored.
    do_reset();
    ena = 1'b0;
    bus.i_ready = 1'b1;
    load(2'd0, 16'h4000);
    stray = 4'b0100;
    base = rx_cnt;
    ena = 1'b1;
    step(1);
    check("t4_req_c1", 32'(bus.o_fifo_rd_req), 32'b0001);
    step(2);
    check("t4_valid_c3", 32'(bus.o_valid), 32'd1);
    check("t4_data_c3", 32'(bus.o_data), 32'h4000);
    stray = 4'b0101;
    step(1);
    check("t4_valid_c4", 32'(bus.o_valid), 32'd0);
    check("t4_req_c4", 32'(bus.o_fifo_rd_req), 32'd0);
    step(1);
    check("t4_busy_c5", 32'(bus.o_busy), 32'd0);
    step(1);
    stray = 4'b0000;
    step(3);
    check("t4_count", 32'(rx_cnt), 32'(base + 1));
    check_rx("t4_w0", base, 2'd0, 16'h4000);

    // Enable gating with one read in flight.
    do_reset();
    ena = 1'b0;
    bus.i_ready = 1'b1;
    load(2'd0, 16'h5000);
    load(2'd0, 16'h5001);
    base = rx_cnt;
    ena = 1'b1;
    step(1);
    check("t5_req_c1", 32'(bus.o_fifo_rd_req), 32'b0001);
    step(1);
    ena = 1'b0;
    #1;
    check("t5_gated", 32'(bus.o_fifo_rd_req), 32'd0);
    step(1);
    check("t5_valid_c3", 32'(bus.o_valid), 32'd1);
    check("t5_data_c3", 32'(bus.o_data), 32'h5000);
    check("t5_req_c3", 32'(bus.o_fifo_rd_req), 32'd0);
    step(1);
    check("t5_valid_c4", 32'(bus.o_valid), 32'd0);
    check("t5_busy_c4", 32'(bus.o_busy), 32'd1);
    step(1);
    check("t5_req_c5", 32'(bus.o_fifo_rd_req), 32'd0);
    check("t5_busy_c5", 32'(bus.o_busy), 32'd1);
    ena = 1'b1;
    #1;
    check("t5_reenable", 32'(bus.o_fifo_rd_req), 32'b0001);
    wait_rx("t5_count", base + 2, 50);
    check_rx("t5_w0", base, 2'd0, 16'h5000);
    check_rx("t5_w1", base + 1, 2'd0, 16'h5001);

    // Asynchronous reset mid-burst with two words buffered.
    do_reset();
    ena = 1'b0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(2'd0, 16'(16'h6000 + i));
    load(2'd1, 16'h6100);
    load(2'd1, 16'h6101);
    ena = 1'b1;
    step(4);
    check("t6_pre_valid", 32'(bus.o_valid), 32'd1);
    check("t6_pre_data", 32'(bus.o_data), 32'h6000);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.o_valid), 32'd0);
    check("t6_rst_req", 32'(bus.o_fifo_rd_req), 32'd0);
    check("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    check("t6_rst_data", 32'(bus.o_data), 32'd0);
    step(2);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    base = rx_cnt;
    step(1);
    check("t6_first_grant", 32'(bus.o_fifo_rd_req), 32'b0001);
    wait_rx("t6_count", base + 6, 60);
    for (int i = 0; i < 4; i++)
      check_rx($sformatf("t6_w%0d", i), base + i, 2'd0, 16'(16'h6002 + i));
    check_rx("t6_w4", base + 4, 2'd1, 16'h6100);
    check_rx("t6_w5", base + 5, 2'd1, 16'h6101);
    step(3);
    check("t6_end_busy", 32'(bus.o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_read_arbiter.md
# fifo_rr_read_arbiter

Round-robin read scheduler that drains NUM_SRC `simple_fifo_anysize` instances, which have a 1-cycle read latency, onto one valid/ready stream. It grants one FIFO at a time for bursts of up to BURST_LEN reads and drives that FIFO's read request. It captures the returned data into a 2-entry output buffer and tags each word with its source index. It sits between the per-channel ingress FIFOs and the shared downstream consumer.

## Interface
- NUM_SRC, 4: number of FIFOs served (≥2).
- DATA_WIDTH, 16: data word width.
- BURST_LEN, 4: maximum consecutive reads per grant (≥1).
- SRC_ID_WIDTH, $clog2(NUM_SRC): derived width of the source tag.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_ena  in  1  global enable; when low, nothing issues and all state holds.
- i_fifo_empty  in  NUM_SRC  per-FIFO empty flag.
- i_fifo_valid  in  NUM_SRC  per-FIFO read-data valid flag.
- i_fifo_data  in  NUM_SRC×DATA_WIDTH  per-FIFO read data, unpacked array [NUM_SRC].
- o_fifo_rd_req  out  NUM_SRC  per-FIFO read request, one-hot or zero, driven combinationally from registered state.
- o_data  out  DATA_WIDTH  output word, taken from the buffer head.
- o_src_id  out  SRC_ID_WIDTH  source index of o_data.
- o_valid  out  1  buffer non-empty.
- i_ready  in  1  downstream accepts; a transfer occurs when o_valid && i_ready.
- o_busy  out  1  state is GRANT, or a read is in flight, or the buffer is non-empty.

## Operation
- Reset values: state IDLE, rr_ptr = NUM_SRC-1, burst_cnt 0, inflight 0, buffer empty, o_valid 0, o_data 0, o_src_id 0, o_fifo_rd_req 0, o_busy 0.
- FSM states:
  - IDLE: if i_ena is high and any i_fifo_empty bit is 0, register owner = the first non-empty index searching upward from rr_ptr+1 modulo NUM_SRC. Set burst_cnt=0 and go to GRANT. Otherwise stay in IDLE. No read request is issued from IDLE.
  - GRANT: issue = i_ena && !i_fifo_empty[owner] && credit_ok. While issue is high, o_fifo_rd_req[owner]=1.
    - On each issue: burst_cnt++, set inflight=1, record inflight_id=owner.
    - Leave to IDLE with rr_ptr=owner when either condition holds:
      - i_fifo_empty[owner]=1 in the current cycle, or
      - an issue makes burst_cnt reach BURST_LEN.
    - If credit_ok=0 and the owner is non-empty, stay in GRANT. The grant is held and burst_cnt is unchanged.
- Credit rule: credit_ok = (occ + inflight − pop) < 2, where occ ∈ {0,1,2} and pop = o_valid && i_ready. Buffer overflow is impossible.
- Capture: when inflight=1 and i_fifo_valid[inflight_id]=1, push {inflight_id, i_fifo_data[inflight_id]} and clear inflight in the same cycle, unless a new issue sets it again.
  - i_fifo_valid from any other index, or while inflight=0, is ignored. This covers a FIFO holding o_valid high while its i_ena is low.
  - Capture proceeds even when i_ena is low, so in-flight data is never lost.
- Buffer: 2-entry FIFO ordered by capture. Push and pop in the same cycle are allowed at any occupancy reachable under the credit rule. o_data and o_src_id hold stable while o_valid=1 and i_ready=0.
- Fairness: after a grant ends, the search restarts just after the previous owner. Every non-empty source is served within NUM_SRC grants.

## Timing
- rd_req in cycle t, FIFO valid in t+1, captured at the end of t+1, o_valid high in t+2. Read-to-output latency is 2 cycles.
- IDLE→GRANT costs 1 cycle per grant, so the burst rate is BURST_LEN words per BURST_LEN+1 cycles with i_ready held high.
- Within a burst with i_ready=1: 1 read per cycle, steady state occ=1, inflight=1.
- i_ready low: at most 2 reads issue, then rd_req deasserts. It reasserts in the same cycle that a pop frees a credit.
- Asynchronous reset mid-burst: all state clears immediately and o_fifo_rd_req drops combinationally. Any data a FIFO returns afterwards is discarded.

## Test plan
- Single source: FIFO 1 holds 3 words (A, B, C), i_ready=1, BURST_LEN=4 → rd_req[1] high for 3 consecutive cycles; o_valid high for 3 cycles starting 2 cycles after the first rd_req, carrying A, B, C with o_src_id=1; returns to IDLE; o_busy falls after C transfers.
- Round-robin: all 4 FIFOs hold 6 words, BURST_LEN=4 → grant order 0,1,2,3,0,1,2,3; bursts of 4 then 2 words; no word lost or reordered within a source.
- Backpressure: i_ready=0 during a burst → exactly 2 words buffered, rd_req stays low, o_data stable; i_ready=1 → reads resume in the first pop cycle.
- Stray valid: hold i_fifo_valid[2]=1 while FIFO 0 is granted, and hold i_fifo_valid[0] high for 3 cycles after a single read → only the one expected word is captured.
- Enable gating: i_ena=0 with one read in flight → the read is captured; no new rd_req issues and state stays frozen until i_ena=1.
- Reset: assert i_rst_n=0 mid-burst with 2 words buffered → outputs immediately show o_valid=0, rd_req=0, o_busy=0; after release, source 0 is granted first.
